power_frame_accumulator: RTL and testbench
==========================================

# power_frame_accumulator

Downstream consumer of the power-of-8 stage. It takes that stage's free-running valid-qualified 64-bit result stream, sums results over frames of up to FRAME_LEN samples, and presents each frame sum to the next stage through a valid/ready output register. The upstream stage has no backpressure, so this block never stalls its input. If the consumer is slow, the newest sum replaces the unread one and an overrun is flagged.

## Interface
- IN_W, 64, width of each input sample (matches the upstream result width)
- FRAME_LEN, 16, samples per full frame; legal range 2..1024
- SUM_W (localparam), IN_W + $clog2(FRAME_LEN), accumulator and output sum width (68 at defaults)
- CNT_W (localparam), $clog2(FRAME_LEN+1), sample-count width (5 at defaults)

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  i_value is valid this cycle; always accepted
- i_value  in  IN_W  sample from the upstream stage
- i_last  in  1  closes the current frame early; only sampled when i_valid=1
- o_valid  out  1  o_sum and o_count hold an unconsumed frame result
- i_ready  in  1  downstream accepts the result when o_valid && i_ready
- o_sum  out  SUM_W  unsigned sum of all samples in the frame
- o_count  out  CNT_W  number of samples in the frame (1..FRAME_LEN)
- o_overrun  out  1  sticky: an unconsumed result was overwritten

## Operation
- State: acc[SUM_W], cnt[CNT_W], result register (o_sum, o_count, o_valid), sticky o_overrun.
- Two-state accumulation FSM:
  - IDLE (cnt=0): no open frame.
  - ACCUM (cnt>0): a frame is open.
- Any i_valid=1 cycle: sample is added. Next values are acc_n = acc + i_value (zero-extended) and cnt_n = cnt + 1.
- Frame closes on that same sample when cnt_n == FRAME_LEN or i_last=1. A single-sample frame is legal.
- On close:
  - result register loads o_sum=acc_n, o_count=cnt_n, o_valid=1.
  - acc and cnt clear to 0 on the same edge, so the next sample starts a new frame with no bubble.
- If no close: acc<=acc_n, cnt<=cnt_n.
- i_last with i_valid=0 is ignored. Empty frames are never emitted.
- Output handshake, evaluated each edge:
  - close this cycle: result loads and o_valid stays/becomes 1, regardless of i_ready.
  - no close, and o_valid && i_ready: o_valid<=0; o_sum/o_count hold their last values.
  - otherwise: result holds.
- Overrun: close while o_valid=1 && i_ready=0 sets o_overrun<=1. The old result is lost; the new result replaces it.
- o_overrun is cleared only by reset.
- Arithmetic is unsigned. SUM_W guarantees no overflow for FRAME_LEN samples of all-ones, so there is no saturation logic.

## Timing
- Reset (synchronous, any cycle, including mid-frame or with o_valid=1): next edge forces acc=0, cnt=0, o_valid=0, o_sum=0, o_count=0, o_overrun=0. A partial frame is discarded.
- Latency: the closing sample is accepted at edge k; o_valid=1 with the final sum is visible from edge k (registered output, 1 cycle after the sample is presented).
- Throughput: one sample per clock, indefinitely. A frame result is produced at most every cycle (i_last on every sample).
- A result must be held stable while o_valid=1 and i_ready=0, unless it is overwritten by a new close (overrun).
- Simultaneous close and consume at the same edge: the old result counts as consumed, the new result is loaded, o_valid stays 1, and there is no overrun.
- Reset asserted in the same cycle as i_valid: reset wins and the sample is dropped.

## Test plan
- Reset, then 16 consecutive samples i_value=1, i_ready=1 -> exactly one o_valid pulse, asserted on the edge of the 16th sample, with o_sum=16, o_count=16.
- Samples 0, 1, 256, 6561 (i^8 for i=0..3) with i_last on the 4th, i_ready=1 -> o_sum=6818, o_count=4; next frame starts clean (following 16×1 gives 16).
- 16 samples of 0xFFFF_FFFF_FFFF_FFFF -> o_sum=0xF_FFFF_FFFF_FFFF_FFF0, o_count=16, with no truncation.
- i_ready=0 with i_last on every sample, values 5 then 7 -> o_sum=7, o_count=1, o_overrun=1 and staying 1; raising i_ready then consumes, o_valid drops next edge.
- Close and consume at the same edge (o_valid=1, i_ready=1, i_last with value 9) -> o_valid stays 1, o_sum=9, o_overrun stays 0.
- Reset pulse after 10 of 16 samples -> all outputs 0 next edge; the following 16×2 samples give o_sum=32, o_count=16.

Source files
------------

// File: rtl/power_frame_accumulator.sv
// power_frame_accumulator: sums valid-qualified samples into frames of up to FRAME_LEN
// and presents each frame sum through a valid/ready result register with sticky overrun.
module power_frame_accumulator #(
    parameter  int IN_W      = 64,
    parameter  int FRAME_LEN = 16,
    localparam int SUM_W     = IN_W + $clog2(FRAME_LEN),
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_value,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [SUM_W-1:0] o_sum,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overrun
);
    logic [SUM_W-1:0] r_acc, r_sum;
    logic [CNT_W-1:0] r_cnt, r_count;
    logic             r_valid, r_overrun;
    logic [SUM_W-1:0] w_acc_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_close;

    assign w_acc_n = r_acc + SUM_W'(i_value);
    assign w_cnt_n = r_cnt + CNT_W'(1);
    assign w_close = i_valid && (i_last || w_cnt_n == CNT_W'(FRAME_LEN));

    // A close restarts the accumulator on the same edge, so back-to-back frames have no bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_close) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= w_acc_n;
            r_count <= w_cnt_n;
            r_valid <= 1'b1;
            if (r_valid && !i_ready)
                r_overrun <= 1'b1;
        end else begin
            if (i_valid) begin
                r_acc <= w_acc_n;
                r_cnt <= w_cnt_n;
            end
            if (r_valid && i_ready)
                r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_sum     = r_sum;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;
endmodule

// File: tb/tb_power_frame_accumulator.sv
// tb_power_frame_accumulator: directed plus random stimulus against a queue-based frame model.
module tb_power_frame_accumulator;
    localparam int IN_W  = 64;
    localparam int FL    = 16;
    localparam int SUM_W = IN_W + $clog2(FL);
    localparam int CNT_W = $clog2(FL + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_valid = 1'b0;
    logic [IN_W-1:0]  i_value = '0;
    logic             i_last = 1'b0;
    logic             i_ready = 1'b0;
    logic             o_valid;
    logic [SUM_W-1:0] o_sum;
    logic [CNT_W-1:0] o_count;
    logic             o_overrun;

    int total = 0;
    int bad = 0;

    logic [63:0]  q[$];
    logic         mv = 1'b0;
    logic         movr = 1'b0;
    logic [127:0] msum = '0;
    int           mcnt = 0;

    power_frame_accumulator #(.IN_W(IN_W), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_value(i_value), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_count(o_count),
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [63:0] val,
                        input logic last, input logic rdy);
        logic         close;
        logic [127:0] s;
        reset = rst; i_valid = v; i_value = val; i_last = last; i_ready = rdy;
        @(posedge clk);
        if (rst) begin
            q.delete(); mv = 0; movr = 0; msum = '0; mcnt = 0;
        end else begin
            close = 1'b0;
            if (v) begin
                q.push_back(val);
                close = last || q.size() == FL;
            end
            if (close) begin
                s = '0;
                foreach (q[k]) s += {64'd0, q[k]};
                if (mv && !rdy) movr = 1'b1;
                msum = s; mcnt = q.size(); mv = 1'b1;
                q.delete();
            end else if (mv && rdy) begin
                mv = 1'b0;
            end
        end
        #1;
        check("valid", {127'd0, o_valid}, {127'd0, mv});
        check("sum", {60'd0, o_sum}, msum);
        check("count", {123'd0, o_count}, 128'(mcnt));
        check("overrun", {127'd0, o_overrun}, {127'd0, movr});
    endtask

    initial begin
        int pulses;
        logic [63:0] v4[4];
        step(1, 0, 0, 0, 1);
        check("reset_valid", {127'd0, o_valid}, 128'd0);

        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 0, 1);
            if (o_valid) pulses++;
        end
        check("t1_pulses", 128'(pulses), 128'd1);
        check("t1_sum", {60'd0, o_sum}, 128'd16);
        check("t1_count", {123'd0, o_count}, 128'd16);
        step(0, 0, 0, 0, 1);
        check("t1_drop", {127'd0, o_valid}, 128'd0);

        v4 = '{64'd0, 64'd1, 64'd256, 64'd6561};
        for (int i = 0; i < 4; i++) step(0, 1, v4[i], i == 3, 1);
        check("t2_sum", {60'd0, o_sum}, 128'd6818);
        check("t2_count", {123'd0, o_count}, 128'd4);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 1);
        check("t2_next", {60'd0, o_sum}, 128'd16);

        for (int i = 0; i < 16; i++) step(0, 1, '1, 0, 1);
        check("t3_sum", {60'd0, o_sum}, 128'hF_FFFF_FFFF_FFFF_FFF0);
        check("t3_count", {123'd0, o_count}, 128'd16);
        step(0, 0, 0, 0, 1);

        step(0, 1, 5, 1, 0);
        step(0, 1, 7, 1, 0);
        check("t4_sum", {60'd0, o_sum}, 128'd7);
        check("t4_count", {123'd0, o_count}, 128'd1);
        check("t4_ovr", {127'd0, o_overrun}, 128'd1);
        step(0, 0, 0, 0, 0);
        check("t4_hold", {127'd0, o_valid}, 128'd1);
        step(0, 0, 0, 0, 1);
        check("t4_consumed", {127'd0, o_valid}, 128'd0);
        check("t4_sticky", {127'd0, o_overrun}, 128'd1);

        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 1, 0);
        step(0, 1, 9, 1, 1);
        check("t5_valid", {127'd0, o_valid}, 128'd1);
        check("t5_sum", {60'd0, o_sum}, 128'd9);
        check("t5_ovr", {127'd0, o_overrun}, 128'd0);

        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1);
        step(1, 1, 5, 0, 1);
        check("t6_rst_sum", {60'd0, o_sum}, 128'd0);
        check("t6_rst_valid", {127'd0, o_valid}, 128'd0);
        for (int i = 0; i < 16; i++) step(0, 1, 2, 0, 1);
        check("t6_sum", {60'd0, o_sum}, 128'd32);
        check("t6_count", {123'd0, o_count}, 128'd16);

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] val;
            case ($urandom_range(0, 3))
                0: val = '1;
                1: val = 64'($urandom_range(0, 15));
                default: val = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, val,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
